// File: rtl/chip_test_sequencer.sv
// chip_test_sequencer
//   Runs one chip test. It walks a vector ROM from address 0 and, for each
//   vector, drives the socket pins, waits a settle time, then samples the
//   pins and compares them. It reports pass/fail, a saturating mismatch
//   count and the first failing vector. The socket is released when the
//   test finishes or on reset.
//
// Ports
//   Clk, Reset      system clock; asynchronous active-low reset
//   Run             raw active-low push button; a falling edge starts a test
//   vec_addr        vector ROM address (ROM data is valid one clock later)
//   vec_drive_en    per-pin drive enable for the current vector
//   vec_drive_val   per-pin drive value for the current vector
//   vec_expect      per-pin expected level at sample time
//   vec_check       per-pin compare enable
//   vec_last        marks the final vector
//   pin_oe, pin_out tri-state enable and drive value per socket pin
//   pin_in          raw, asynchronous socket pin levels
//   busy, done      test in progress; test finished (held until next press)
//   pass            valid while done: no mismatching vector was seen
//   err_count       mismatching vectors, saturating at 255
//   fail_addr       address of the first mismatching vector
//   fail_pins       mismatch mask of the first mismatching vector
//   fsm_state       current FSM state, exposed for debug and checkers
//
// ROM timing: vec_addr is registered. The ROM returns the vector for
// vec_addr during the clock that follows FETCH, which is the APPLY state.
// There is no valid/ready handshake on this interface. The sequencer
// only samples vec_* in APPLY.
`timescale 1ns/1ps

module chip_test_sequencer #(
    parameter int NUM_PINS      = 16,
    parameter int ADDR_W        = 6,
    parameter int SETTLE_CYCLES = 50,
    parameter int STOP_ON_FAIL  = 0
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Run,
    output logic [ADDR_W-1:0]   vec_addr,
    input  logic [NUM_PINS-1:0] vec_drive_en,
    input  logic [NUM_PINS-1:0] vec_drive_val,
    input  logic [NUM_PINS-1:0] vec_expect,
    input  logic [NUM_PINS-1:0] vec_check,
    input  logic                vec_last,
    output logic [NUM_PINS-1:0] pin_oe,
    output logic [NUM_PINS-1:0] pin_out,
    input  logic [NUM_PINS-1:0] pin_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [7:0]          err_count,
    output logic [ADDR_W-1:0]   fail_addr,
    output logic [NUM_PINS-1:0] fail_pins,
    output logic [2:0]          fsm_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        APPLY  = 3'd2,
        SETTLE = 3'd3,
        SAMPLE = 3'd4,
        DONE   = 3'd5
    } state_t;

    // The counter counts down from SETTLE_CYCLES-1 to 0. That value always
    // fits in clog2(SETTLE_CYCLES) bits, because SETTLE_CYCLES is at least 3.
    localparam int CNT_W = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t                state;
    logic   [CNT_W-1:0]    settle_cnt;
    logic   [2:0]          run_sync;
    logic   [NUM_PINS-1:0] pin_meta;
    logic   [NUM_PINS-1:0] pin_sync;
    logic   [NUM_PINS-1:0] exp_q;
    logic   [NUM_PINS-1:0] chk_q;
    logic                  last_q;
    logic                  press;
    logic   [NUM_PINS-1:0] mism;
    logic   [7:0]          err_next;
    logic                  finish;

    // Button and pin synchronizers. The button chain resets to 1, the
    // released level, so that leaving reset never looks like a press.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            run_sync <= 3'b111;
            pin_meta <= '0;
            pin_sync <= '0;
        end else begin
            run_sync <= {run_sync[1:0], Run};
            pin_meta <= pin_in;
            pin_sync <= pin_meta;
        end
    end

    assign press    = run_sync[2] & ~run_sync[1];
    assign mism     = (pin_sync ^ exp_q) & chk_q;
    assign err_next = ((mism != '0) && (err_count != 8'hFF)) ? err_count + 8'd1 : err_count;
    // Stopping at the top address keeps the address from wrapping back to 0.
    assign finish   = last_q || (vec_addr == '1) || ((STOP_ON_FAIL != 0) && (mism != '0));
    assign fsm_state = state;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            vec_addr   <= '0;
            pin_oe     <= '0;
            pin_out    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_addr  <= '0;
            fail_pins  <= '0;
            exp_q      <= '0;
            chk_q      <= '0;
            last_q     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (press) begin
                        state     <= FETCH;
                        vec_addr  <= '0;
                        err_count <= '0;
                        fail_addr <= '0;
                        fail_pins <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                FETCH: state <= APPLY;
                APPLY: begin
                    // The pins change only here. They hold their values
                    // through the next FETCH, so there is no glitch between
                    // vectors.
                    pin_oe     <= vec_drive_en;
                    pin_out    <= vec_drive_val;
                    exp_q      <= vec_expect;
                    chk_q      <= vec_check;
                    last_q     <= vec_last;
                    settle_cnt <= SETTLE_LOAD;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                SAMPLE: begin
                    err_count <= err_next;
                    // An err_count of zero means this mismatch is the first one.
                    if ((mism != '0) && (err_count == 8'd0)) begin
                        fail_addr <= vec_addr;
                        fail_pins <= mism;
                    end
                    if (finish) begin
                        state   <= DONE;
                        pin_oe  <= '0;
                        pin_out <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_next == 8'd0);
                    end else begin
                        vec_addr <= vec_addr + 1'b1;
                        state    <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
